// File: rtl/fp_chia_if.sv
// Operand/result handshake bundle for the fp_chia FP32 divider.
// The slave modport is the divider; the master modport is the producer/consumer side.
interface fp_chia_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] InA;
  logic [31:0] InB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;

  modport slave (
    input  in_valid, InA, InB, out_ready,
    output in_ready, out_valid, Out
  );

  modport master (
    output in_valid, InA, InB, out_ready,
    input  in_ready, out_valid, Out
  );
endinterface

// File: rtl/fp_chia.sv
// Sequential FP32 divider (Out = InA / InB), radix-2 restoring, one quotient bit per clock.
// Define FP_CHIA_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_chia (
  input  logic     clk,
  input  logic     rst_n,
  fp_chia_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        sign;
  logic        zero_a;
  logic        zero_b;
  logic [7:0]  e;
  logic [23:0] mb;
  logic [25:0] rem;
  logic [25:0] q;
  logic [4:0]  cnt;
  logic [31:0] out_r;

  logic [25:0] rem_diff;
  logic        rem_ge;
  logic [22:0] mant;
  logic [7:0]  exp_n;
  logic [31:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = DIV;
      DIV:  if (cnt == 5'd25) state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  assign bus.Out  = out_r;
  assign rem_diff = rem - {2'b00, mb};
  assign rem_ge   = (rem >= {2'b00, mb});

  // Quotient of two normalised mantissas lies in (0.5, 2), so q[25] or q[24] is the leading one.
  always_comb begin
    if (q[25]) begin
      mant  = q[24:2];
      exp_n = e;
    end else begin
      mant  = q[23:1];
      exp_n = e - 8'd1;
    end
`ifdef FP_CHIA_RNE_EN
    begin
      logic        guard;
      logic        sticky;
      logic [23:0] mant_inc;
      guard    = q[25] ? q[1] : q[0];
      sticky   = q[25] ? (q[0] | (rem != 26'd0)) : (rem != 26'd0);
      mant_inc = {1'b0, mant} + 24'd1;
      if (guard & (sticky | mant[0])) begin
        mant = mant_inc[22:0];
        if (mant_inc[23]) exp_n = exp_n + 8'd1;
      end
    end
`endif
    if (zero_a) begin
      result = 32'h0000_0000;
    end else if (zero_b) begin
      result = {sign, 8'hFF, 23'd0};
    end else begin
      result = {sign, exp_n, mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      zero_a <= 1'b0;
      zero_b <= 1'b0;
      e      <= 8'd0;
      mb     <= 24'd0;
      rem    <= 26'd0;
      q      <= 26'd0;
      cnt    <= 5'd0;
      out_r  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign   <= bus.InA[31] ^ bus.InB[31];
            zero_a <= (bus.InA == 32'd0);
            zero_b <= (bus.InB == 32'd0);
            e      <= bus.InA[30:23] - bus.InB[30:23] + 8'd127;
            mb     <= {1'b1, bus.InB[22:0]};
            rem    <= {2'b01, bus.InA[22:0]};
            q      <= 26'd0;
            cnt    <= 5'd0;
          end
        end
        DIV: begin
          if (rem_ge) begin
            rem <= {rem_diff[24:0], 1'b0};
            q   <= {q[24:0], 1'b1};
          end else begin
            rem <= {rem[24:0], 1'b0};
            q   <= {q[24:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        NORM: out_r <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_chia.sv
// Self-checking bench for fp_chia: latency, arithmetic, zero cases, backpressure, mid-op reset.
// Expected results are queued at acceptance and compared when out_valid rises.
module tb_fp_chia;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] exp_q[$];

  fp_chia_if bus ();

  fp_chia dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_CHIA_RNE_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    bus.InA      = a;
    bus.InB      = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(expv);
  endtask

  // Counts edges from acceptance until out_valid, noting any cycle where in_ready was high.
  task automatic wait_result(output int cycles, output int busy_viol);
    cycles    = 0;
    busy_viol = 0;
    while (bus.out_valid !== 1'b1 && cycles < 200) begin
      if (bus.in_ready !== 1'b0) busy_viol++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.InA       = 32'd0;
    bus.InB       = 32'd0;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.Out !== 32'h0) begin errors++; $display("FAIL reset Out: got %h expected 00000000", bus.Out); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [31:0] ta [7] = '{32'h40C00000, 32'h3F800000, 32'hBFC00000, 32'h3F800000,
                            32'h40E00000, 32'hC0C00000, 32'h3F800000};
    logic [31:0] tb [7] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F800000,
                            32'h40000000, 32'hC0000000, 32'h40800000};
    logic [31:0] te [7] = '{32'h40400000, ONE_THIRD, 32'hC0400000, 32'h3F800000,
                            32'h40600000, 32'h40400000, 32'h3E800000};
    int cyc;
    int busy;
    logic [31:0] expv;
    for (int i = 0; i < 7; i++) begin
      send_op(ta[i], tb[i], te[i]);
      wait_result(cyc, busy);
      checks++;
      if (cyc !== 27) begin errors++; $display("FAIL arith[%0d] latency: got %0d expected 27", i, cyc); end
      checks++;
      if (busy !== 0) begin errors++; $display("FAIL arith[%0d] in_ready busy: got %0d high cycles expected 0", i, busy); end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL arith[%0d] scoreboard: got empty queue expected entry", i);
      end else begin
        expv = exp_q.pop_front();
        if (bus.Out !== expv) begin errors++; $display("FAIL arith[%0d] Out: got %h expected %h", i, bus.Out, expv); end
      end
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL arith[%0d] return idle: got in_ready=%b out_valid=%b expected 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] ta [3] = '{32'h00000000, 32'h3F800000, 32'h00000000};
    logic [31:0] tb [3] = '{32'h3F800000, 32'h00000000, 32'h00000000};
    logic [31:0] te [3] = '{32'h00000000, 32'h7F800000, 32'h00000000};
    int cyc;
    int busy;
    logic [31:0] expv;
    for (int i = 0; i < 3; i++) begin
      send_op(ta[i], tb[i], te[i]);
      wait_result(cyc, busy);
      checks++;
      if (cyc !== 27) begin errors++; $display("FAIL zero[%0d] latency: got %0d expected 27", i, cyc); end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL zero[%0d] scoreboard: got empty queue expected entry", i);
      end else begin
        expv = exp_q.pop_front();
        if (bus.Out !== expv) begin errors++; $display("FAIL zero[%0d] Out: got %h expected %h", i, bus.Out, expv); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int busy;
    int seen;
    logic [31:0] expv;
    bus.out_ready = 1'b0;
    send_op(32'h40E00000, 32'h40000000, 32'h40600000);
    wait_result(cyc, busy);
    expv = 32'hDEADBEEF;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL bp scoreboard: got empty queue expected entry");
    end else begin
      expv = exp_q.pop_front();
      if (bus.Out !== expv) begin errors++; $display("FAIL bp Out: got %h expected %h", bus.Out, expv); end
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.InA      = $urandom;
      bus.InB      = $urandom;
      @(posedge clk); #1;
      checks++;
      if (bus.Out !== expv || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold[%0d]: got Out=%h out_valid=%b in_ready=%b expected %h/1/0", i, bus.Out, bus.out_valid, bus.in_ready, expv);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL bp spurious result: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    int busy;
    int seen;
    logic [31:0] expv;
    send_op(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Out !== 32'h0) begin
      errors++;
      $display("FAIL mid reset outputs: got in_ready=%b out_valid=%b Out=%h expected 1/0/00000000", bus.in_ready, bus.out_valid, bus.Out);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid reset stale result: got %0d valid cycles expected 0", seen); end
    send_op(32'h40C00000, 32'h40000000, 32'h40400000);
    wait_result(cyc, busy);
    checks++;
    if (cyc !== 27) begin errors++; $display("FAIL post reset latency: got %0d expected 27", cyc); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL post reset scoreboard: got empty queue expected entry");
    end else begin
      expv = exp_q.pop_front();
      if (bus.Out !== expv) begin errors++; $display("FAIL post reset Out: got %h expected %h", bus.Out, expv); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_arith();
    test_zero();
    test_backpressure();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
